// File: rtl/layer_compositor.sv
// layer_compositor: pipelined N-layer alpha compositor with alpha
// double-buffering committed at frame start.
//
// Ports:
//   clk_in, rst_n_in      pixel clock, async active-low reset
//   pixel_valid_in        layers_in valid this cycle
//   layers_in             layer k at [k*3*CH_BITS +: 3*CH_BITS]
//   alpha_in              alpha of layer k>=1 at [(k-1)*ALPHA_BITS +: ALPHA_BITS]
//   alpha_load_in         capture alpha_in into shadow
//   frame_start_in        commit shadow to active if pending
//   pixel_valid_out       composited pixel valid
//   pixel_out             composited pixel {R,G,B}
//   alpha_pending_out     shadow captured, not yet committed
//
// Optional: define LAYER_COMPOSITOR_CHROMA_KEY_EN to use KEY_COLOR as the
// transparent key instead of all-zero.
module layer_compositor #(
  parameter int CH_BITS    = 4,
  parameter int ALPHA_BITS = 3,
  parameter int NUM_LAYERS = 2,
  parameter int KEY_COLOR  = 0
) (
  input  logic                                   clk_in,
  input  logic                                   rst_n_in,
  input  logic                                   pixel_valid_in,
  input  logic [NUM_LAYERS*3*CH_BITS-1:0]        layers_in,
  input  logic [(NUM_LAYERS-1)*ALPHA_BITS-1:0]   alpha_in,
  input  logic                                   alpha_load_in,
  input  logic                                   frame_start_in,
  output logic                                   pixel_valid_out,
  output logic [3*CH_BITS-1:0]                   pixel_out,
  output logic                                   alpha_pending_out
);

  localparam int PW   = 3 * CH_BITS;
  localparam int AW   = (NUM_LAYERS - 1) * ALPHA_BITS;
  localparam int ONE  = 2 ** (ALPHA_BITS - 1);
  localparam int IW   = CH_BITS + ALPHA_BITS + 1;
  localparam int CMAX = 2 ** CH_BITS - 1;

  localparam logic [ALPHA_BITS-1:0] A_ONE  = ALPHA_BITS'(ONE);
  localparam logic [ALPHA_BITS-1:0] A_HALF = ALPHA_BITS'(ONE / 2);

`ifdef LAYER_COMPOSITOR_CHROMA_KEY_EN
  localparam logic [PW-1:0] KEY = PW'(KEY_COLOR);
`else
  // Key is all-zero; KEY_COLOR has no effect in this build.
  localparam logic [PW-1:0] KEY = PW'(KEY_COLOR * 0);
`endif

  // Stage s holds NUM_LAYERS-s words: slot 0 is the accumulator,
  // slots 1.. are the not-yet-blended layers s+1.. in order.
  // All stages are packed back to back in one vector.
  function automatic int off(input int s);
    return PW * (s * NUM_LAYERS - (s * (s - 1)) / 2);
  endfunction

  localparam int TOT     = off(NUM_LAYERS);
  localparam int OUT_OFF = off(NUM_LAYERS - 1);

  function automatic logic [PW-1:0] blend(
    input logic [PW-1:0]         acc,
    input logic [PW-1:0]         lay,
    input logic [ALPHA_BITS-1:0] al
  );
    logic [ALPHA_BITS-1:0] ac;
    logic [IW-1:0]         t;
    logic [IW-1:0]         sh;
    logic [PW-1:0]         r;
    ac = (al > A_ONE) ? A_ONE : al;
    r  = acc;
    if (lay == KEY) begin
      r = acc;
    end else if (acc == KEY) begin
      r = lay;
    end else begin
      for (int c = 0; c < 3; c++) begin
        t = IW'(lay[c*CH_BITS +: CH_BITS]) * IW'(ac)
          + IW'(acc[c*CH_BITS +: CH_BITS])
            * (IW'(A_ONE) - IW'(ac))
          + IW'(ONE / 2);
        sh = t >> (ALPHA_BITS - 1);
        r[c*CH_BITS +: CH_BITS] = (sh > IW'(CMAX))
          ? CH_BITS'(CMAX) : sh[CH_BITS-1:0];
      end
    end
    return r;
  endfunction

  // Alpha double buffer
  logic [AW-1:0] act_q, act_d;
  logic [AW-1:0] shd_q, shd_d;
  logic          pend_q, pend_d;

  always_comb begin
    act_d  = act_q;
    shd_d  = shd_q;
    pend_d = pend_q;
    if (alpha_load_in) begin
      shd_d  = alpha_in;
      // Load coinciding with frame start commits straight through.
      pend_d = !frame_start_in;
      if (frame_start_in) begin
        act_d = alpha_in;
      end
    end else if (frame_start_in && pend_q) begin
      act_d  = shd_q;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      act_q  <= {(NUM_LAYERS-1){A_HALF}};
      shd_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      act_q  <= act_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
    end
  end

  // Pipeline
  logic [NUM_LAYERS-1:0] v_q, v_d;
  logic [TOT-1:0]        pipe_q, pipe_d;

  always_comb begin
    v_d    = {v_q[NUM_LAYERS-2:0], pixel_valid_in};
    pipe_d = '0;
    if (pixel_valid_in) begin
      pipe_d[0 +: NUM_LAYERS*PW] = layers_in;
    end
    for (int s = 1; s < NUM_LAYERS; s++) begin
      if (v_q[s-1]) begin
        pipe_d[off(s) +: PW] = blend(
          pipe_q[off(s-1) +: PW],
          pipe_q[off(s-1) + PW +: PW],
          act_q[(s-1)*ALPHA_BITS +: ALPHA_BITS]);
        for (int j = 1; j < NUM_LAYERS - s; j++) begin
          pipe_d[off(s) + j*PW +: PW] =
            pipe_q[off(s-1) + (j+1)*PW +: PW];
        end
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      v_q    <= '0;
      pipe_q <= '0;
    end else begin
      v_q    <= v_d;
      pipe_q <= pipe_d;
    end
  end

  assign pixel_valid_out   = v_q[NUM_LAYERS-1];
  assign pixel_out         = pipe_q[OUT_OFF +: PW];
  assign alpha_pending_out = pend_q;

endmodule

// File: tb/tb_layer_compositor.sv
// tb_layer_compositor: vector table, hand sequences and random streams
// for 2-layer and 3-layer compositors against a reference model.
module tb_layer_compositor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        v2_i, ld2, fs2;
  logic [23:0] l2_i;
  logic [2:0]  a2_i;
  logic        v2_o, pd2_o;
  logic [11:0] p2_o;

  logic        v3_i, ld3, fs3;
  logic [35:0] l3_i;
  logic [5:0]  a3_i;
  logic        v3_o, pd3_o;
  logic [11:0] p3_o;

  layer_compositor u_dut2 (
    .clk_in(clk), .rst_n_in(rst_n),
    .pixel_valid_in(v2_i), .layers_in(l2_i),
    .alpha_in(a2_i), .alpha_load_in(ld2),
    .frame_start_in(fs2), .pixel_valid_out(v2_o),
    .pixel_out(p2_o), .alpha_pending_out(pd2_o)
  );

  layer_compositor #(.NUM_LAYERS(3)) u_dut3 (
    .clk_in(clk), .rst_n_in(rst_n),
    .pixel_valid_in(v3_i), .layers_in(l3_i),
    .alpha_in(a3_i), .alpha_load_in(ld3),
    .frame_start_in(fs3), .pixel_valid_out(v3_o),
    .pixel_out(p3_o), .alpha_pending_out(pd3_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference alpha state per DUT (0: 2 layers, 1: 3 layers)
  int act_m [2][2];
  int shd_m [2][2];
  bit pend_m [2];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 2; k++) begin
        act_m[d][k] = 2;
        shd_m[d][k] = 0;
      end
      pend_m[d] = 0;
    end
  endtask

  // Weighted average of 4-bit channels, alpha out of 4
  function automatic int blend_m(int a_px, int l_px, int al);
    int r, lc, ac, v;
    if (al > 4) al = 4;
    if (l_px == 0) return a_px;
    if (a_px == 0) return l_px;
    r = 0;
    for (int c = 0; c < 3; c++) begin
      lc = (l_px >> (4*c)) & 15;
      ac = (a_px >> (4*c)) & 15;
      v = (lc * al + ac * (4 - al) + 2) / 4;
      if (v > 15) v = 15;
      r = r | (v << (4*c));
    end
    return r;
  endfunction

  function automatic int comp_m(int d, int l0, int l1, int l2);
    int acc;
    acc = blend_m(l0, l1, act_m[d][0]);
    if (d == 1) acc = blend_m(acc, l2, act_m[d][1]);
    return acc;
  endfunction

  function automatic logic out_v(int d);
    return (d == 1) ? v3_o : v2_o;
  endfunction

  function automatic logic [11:0] out_p(int d);
    return (d == 1) ? p3_o : p2_o;
  endfunction

  function automatic logic out_pd(int d);
    return (d == 1) ? pd3_o : pd2_o;
  endfunction

  task automatic set_in(int d, bit v, int l0, int l1, int l2);
    if (d == 0) begin
      v2_i = v;
      l2_i = {l1[11:0], l0[11:0]};
    end else begin
      v3_i = v;
      l3_i = {l2[11:0], l1[11:0], l0[11:0]};
    end
  endtask

  task automatic alpha_op(int d, bit ld, bit fs, int x0, int x1);
    if (d == 0) begin
      ld2 = ld; fs2 = fs; a2_i = x0[2:0];
    end else begin
      ld3 = ld; fs3 = fs; a3_i = {x1[2:0], x0[2:0]};
    end
    step();
    ld2 = 0; fs2 = 0; ld3 = 0; fs3 = 0;
    if (ld && fs) begin
      act_m[d][0] = x0; act_m[d][1] = x1;
      shd_m[d][0] = x0; shd_m[d][1] = x1;
      pend_m[d] = 0;
    end else if (ld) begin
      shd_m[d][0] = x0; shd_m[d][1] = x1;
      pend_m[d] = 1;
    end else if (fs && pend_m[d]) begin
      act_m[d][0] = shd_m[d][0];
      act_m[d][1] = shd_m[d][1];
      pend_m[d] = 0;
    end
    chk("pending", out_pd(d), pend_m[d]);
  endtask

  // One pixel through an otherwise idle pipeline, checking latency
  task automatic pix(int d, int l0, int l1, int l2, int exp,
                     string nm);
    int nl;
    nl = (d == 1) ? 3 : 2;
    set_in(d, 1, l0, l1, l2);
    step();
    set_in(d, 0, 0, 0, 0);
    for (int i = 1; i < nl; i++) begin
      chk({nm, "_early"}, out_v(d), 0);
      step();
    end
    chk({nm, "_vld"}, out_v(d), 1);
    chk({nm, "_pix"}, out_p(d), exp);
    step();
    chk({nm, "_idle"}, {out_v(d), out_p(d)}, 0);
  endtask

  function automatic int rnd_px();
    if ($urandom_range(0, 3) == 0) return 0;
    return $urandom_range(0, 4095);
  endfunction

  task automatic stream(int d, int bursts, int len);
    int nl, l0, l1, l2, ev, ep;
    bit v;
    int qv[$];
    int qp[$];
    nl = (d == 1) ? 3 : 2;
    for (int b = 0; b < bursts; b++) begin
      alpha_op(d, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)),
               $urandom_range(0, 7), $urandom_range(0, 7));
      qv.delete();
      qp.delete();
      for (int c = 0; c < len + nl; c++) begin
        v = (c < len) && ($urandom_range(0, 9) < 7);
        l0 = rnd_px(); l1 = rnd_px(); l2 = rnd_px();
        set_in(d, v, l0, l1, l2);
        qv.push_back(v ? 1 : 0);
        qp.push_back(v ? comp_m(d, l0, l1, l2) : 0);
        step();
        if (qv.size() == nl) begin
          ev = qv.pop_front();
          ep = qp.pop_front();
          chk("stream_vld", out_v(d), ev);
          chk("stream_pix", out_p(d), ep);
        end
      end
      set_in(d, 0, 0, 0, 0);
    end
  endtask

  typedef struct {
    int    l0;
    int    l1;
    int    a;
    int    exp;
    string nm;
  } vec_t;

  vec_t tbl [9];

  initial begin
    tbl[0] = '{'h888, 'h0F0, 2, 'h4C4, "half"};
    tbl[1] = '{'h888, 'h000, 2, 'h888, "l1_clear"};
    tbl[2] = '{'h000, 'h0F0, 5, 'h0F0, "l0_clear"};
    tbl[3] = '{'h888, 'h0F0, 7, 'h0F0, "clamp7"};
    tbl[4] = '{'h888, 'h0F0, 0, 'h888, "alpha0"};
    tbl[5] = '{'h888, 'h0F0, 4, 'h0F0, "alpha4"};
    tbl[6] = '{'h123, 'h456, 1, 'h234, "alpha1"};
    tbl[7] = '{'hF0F, 'h0F0, 3, 'h4B4, "alpha3"};
    tbl[8] = '{'hFFF, 'hFFF, 3, 'hFFF, "sat"};

    v2_i = 0; l2_i = '0; a2_i = '0; ld2 = 0; fs2 = 0;
    v3_i = 0; l3_i = '0; a3_i = '0; ld3 = 0; fs3 = 0;
    model_reset();

    step();
    step();
    chk("rst_vld2", v2_o, 0);
    chk("rst_pix2", p2_o, 0);
    chk("rst_pend2", pd2_o, 0);
    chk("rst_vld3", v3_o, 0);
    chk("rst_pix3", p3_o, 0);
    chk("rst_pend3", pd3_o, 0);
    rst_n = 1;
    step();

    pix(0, 'h888, 'h0F0, 0, 'h4C4, "rst_alpha");
    alpha_op(0, 1, 0, 2, 0);
    alpha_op(0, 0, 1, 0, 0);
    pix(0, 'h888, 'h0F0, 0, 'h4C4, "commit2");

    alpha_op(0, 1, 0, 0, 0);
    pix(0, 'h888, 'h0F0, 0, 'h4C4, "midframe");
    chk("midframe_pend", pd2_o, 1);
    alpha_op(0, 0, 1, 0, 0);
    pix(0, 'h888, 'h0F0, 0, 'h888, "after_fs");
    alpha_op(0, 0, 1, 0, 0);
    pix(0, 'h888, 'h0F0, 0, 'h888, "fs_nopend");

    alpha_op(0, 1, 0, 4, 0);
    alpha_op(0, 1, 0, 1, 0);
    alpha_op(0, 0, 1, 0, 0);
    pix(0, 'h888, 'h0F0, 0, 'h6A6, "last_load");

    for (int i = 0; i < 9; i++) begin
      alpha_op(0, 1, 1, tbl[i].a, 0);
      pix(0, tbl[i].l0, tbl[i].l1, 0, tbl[i].exp, tbl[i].nm);
    end

    alpha_op(1, 1, 1, 4, 2);
    pix(1, 'h111, 'h0F0, 'hF00, 'h880, "l3_full");
    pix(1, 'h111, 'h0F0, 'h000, 'h0F0, "l3_clear2");

    stream(0, 6, 40);
    stream(1, 6, 40);

    // Reset with pixels in flight and a pending load
    alpha_op(0, 1, 1, 0, 0);
    alpha_op(1, 1, 1, 0, 0);
    alpha_op(0, 1, 0, 5, 0);
    set_in(0, 1, 'h888, 'h0F0, 0);
    set_in(1, 1, 'h111, 'h0F0, 'hF00);
    step();
    step();
    chk("pre_rst_vld", v2_o, 1);
    #3;
    rst_n = 0;
    #1;
    chk("async_vld2", v2_o, 0);
    chk("async_pix2", p2_o, 0);
    chk("async_pend2", pd2_o, 0);
    chk("async_vld3", v3_o, 0);
    chk("async_pix3", p3_o, 0);
    set_in(0, 0, 0, 0, 0);
    set_in(1, 0, 0, 0, 0);
    model_reset();
    step();
    rst_n = 1;
    step();
    pix(0, 'h888, 'h0F0, 0, 'h4C4, "post_rst2");
    pix(1, 'h111, 'h0F0, 'hF00,
        comp_m(1, 'h111, 'h0F0, 'hF00), "post_rst3");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
